ps2_keyboard: RTL and testbench

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_keyboard_if.sv | 13 +
 rtl/ps2_rx_fifo.sv | 47 ++++
 rtl/ps2_keyboard.sv | 81 ++++++++
 tb/tb_ps2_keyboard.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared constants and types.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_LEN  = 11;
  localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;
  localparam logic [7:0]  PS2_EXT_PREFIX = 8'hE0;
  localparam int unsigned PS2_FIFO_DEPTH = 8;

  // Bit counter value when the stop bit is on the wire.
  localparam logic [3:0]  PS2_LAST_BIT   = 4'(PS2_FRAME_LEN - 1);

  typedef logic [7:0] ps2_byte_t;

endpackage

// File: rtl/ps2_keyboard_if.sv
// Received-byte handshake between the PS/2 receiver (master) and its consumer (slave).
interface ps2_keyboard_if;
  import ps2_pkg::*;

  ps2_byte_t data;
  logic      ready;
  logic      nextdata_n;
  logic      overflow;

  modport master (output data, output ready, output overflow, input nextdata_n);
  modport slave  (input data, input ready, input overflow, output nextdata_n);

endinterface

// File: rtl/ps2_rx_fifo.sv
// Received-byte FIFO: combinational head read, extra pointer bit separates full from empty.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = PS2_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  ps2_byte_t wdata,
  input  logic      pop,
  output ps2_byte_t rdata,
  output logic      empty,
  output logic      full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  ps2_byte_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises ps2_clk, deserialises 11-bit frames into a byte FIFO.
// Define PS2_PARITY_CHECK_EN to also reject frames with bad odd parity.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = PS2_FIFO_DEPTH
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_keyboard_if.master kbd
);

  logic [2:0] ps2_clk_sync;
  logic [9:0] frame;
  logic [3:0] count;
  logic       overflow_q;
  logic       fall;
  logic       frame_done;
  logic       frame_ok;
  logic       fifo_full;
  logic       fifo_empty;
  ps2_byte_t  fifo_rdata;

  always_comb begin
    fall       = ps2_clk_sync[2] && !ps2_clk_sync[1];
    frame_done = fall && (count == PS2_LAST_BIT);
    // Stop bit is judged straight off the wire; it is never stored in frame.
`ifdef PS2_PARITY_CHECK_EN
    frame_ok   = !frame[0] && ps2_data && (^frame[9:1]);
`else
    frame_ok   = !frame[0] && ps2_data;
`endif
  end

`ifndef PS2_PARITY_CHECK_EN
  logic unused_parity;
  assign unused_parity = frame[9];
`endif

  always_ff @(posedge clk) begin
    if (clrn) begin
      ps2_clk_sync <= '1;
      frame        <= '0;
      count        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      ps2_clk_sync <= {ps2_clk_sync[1:0], ps2_clk};
      if (fall) begin
        if (count == PS2_LAST_BIT) begin
          count <= '0;
          if (frame_ok && fifo_full) overflow_q <= 1'b1;
        end else begin
          frame[count] <= ps2_data;
          count        <= count + 4'd1;
        end
      end
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (clrn),
    .push  (frame_done && frame_ok),
    .wdata (frame[8:1]),
    .pop   (!kbd.nextdata_n),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    kbd.data     = fifo_rdata;
    kbd.ready    = !fifo_empty;
    kbd.overflow = overflow_q;
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: bit-banged PS/2 frames, expected bytes queued at send time.
module tb_ps2_keyboard;
  import ps2_pkg::*;

  localparam int unsigned FIFO_DEPTH = 8;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic clk;
  logic clrn;
  logic ps2_clk;
  logic ps2_data;

  ps2_keyboard_if kbd ();

  ps2_keyboard #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbd      (kbd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovf = 1'b0;

  task automatic send_bit(input logic v);
    @(negedge clk);
    ps2_data = v;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // pop_at: 1..3 pops the head on that clk after the stop-bit edge; 0 = no pop.
  task automatic send_frame(input logic [7:0] b, input bit good_par, input bit chk_lat,
                            input int unsigned pop_at);
    logic [10:0] bits;
    logic [7:0]  e;
    int unsigned lat;
    bits = {1'b1, (good_par ? ~^b : ^b), b, 1'b0};
    if (good_par || !PARITY_EN) begin
      if (exp_q.size() == FIFO_DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(b);
    end
    for (int unsigned i = 0; i < 10; i++) send_bit(bits[i]);
    @(negedge clk);
    ps2_data = bits[10];
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    lat = 0;
    for (int unsigned c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (chk_lat && lat == 0 && kbd.ready === 1'b1) lat = c;
      if (c == pop_at) begin
        e = exp_q.pop_front();
        checks++;
        if (kbd.ready !== 1'b1 || kbd.data !== e) begin
          errors++;
          $display("FAIL mid_pop: ready=%b data=%h, want ready=1 data=%h", kbd.ready, kbd.data, e);
        end
        kbd.nextdata_n = 1'b0;
      end else begin
        kbd.nextdata_n = 1'b1;
      end
    end
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    if (chk_lat) begin
      checks++;
      if (lat == 0 || lat > 4) begin
        errors++;
        $display("FAIL latency: ready seen at clk %0d after stop edge (0=never), want 1..4", lat);
      end
    end
  endtask

  task automatic drain_one(input string name);
    logic [7:0] e;
    @(negedge clk);
    checks++;
    if (kbd.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", name, kbd.ready);
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue want an expected byte", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (kbd.data !== e) begin
        errors++;
        $display("FAIL %s data: got %h want %h", name, kbd.data, e);
      end
    end
    kbd.nextdata_n = 1'b0;
    @(negedge clk);
    kbd.nextdata_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (kbd.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", kbd.ready);
    end
    checks++;
    if (kbd.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b want 0", kbd.overflow);
    end
  endtask

  task automatic test_single();
    bit exp_rdy;
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    drain_one("single");
    @(negedge clk);
    exp_rdy = (exp_q.size() != 0);
    checks++;
    if (kbd.ready !== exp_rdy) begin
      errors++;
      $display("FAIL single_empty: ready=%b want %b", kbd.ready, exp_rdy);
    end
  endtask

  task automatic test_break();
    send_frame(PS2_BREAK_CODE, 1'b1, 1'b0, 0);
    send_frame(8'h1C, 1'b1, 1'b0, 0);
    drain_one("break_f0");
    drain_one("break_1c");
    @(negedge clk);
    checks++;
    if (kbd.ready !== 1'b0) begin
      errors++;
      $display("FAIL break_empty: ready=%b want 0", kbd.ready);
    end
  endtask

  task automatic test_parity();
    bit exp_rdy;
    send_frame(8'h1C, 1'b0, 1'b0, 0);
    @(negedge clk);
    exp_rdy = (exp_q.size() != 0);
    checks++;
    if (kbd.ready !== exp_rdy) begin
      errors++;
      $display("FAIL parity_ready: ready=%b want %b", kbd.ready, exp_rdy);
    end
    while (exp_q.size() != 0) drain_one("parity");
    send_frame(PS2_EXT_PREFIX, 1'b1, 1'b0, 0);
    drain_one("after_bad_frame");
  endtask

  task automatic test_overflow();
    for (int unsigned i = 0; i < FIFO_DEPTH + 1; i++)
      send_frame(8'h30 + 8'(i * 7), 1'b1, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (kbd.overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow_set: got %b want %b", kbd.overflow, exp_ovf);
    end
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) drain_one("overflow_order");
    @(negedge clk);
    checks++;
    if (kbd.ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drained: ready=%b want 0", kbd.ready);
    end
    checks++;
    if (kbd.overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow_sticky: got %b want %b", kbd.overflow, exp_ovf);
    end
  endtask

  task automatic test_back_to_back();
    for (int unsigned k = 1; k <= 3; k++) begin
      send_frame(8'hA0 + 8'(k), 1'b1, 1'b0, 0);
      send_frame(8'hB0 + 8'(k), 1'b1, 1'b0, k);
      while (exp_q.size() != 0) drain_one("push_pop");
      @(negedge clk);
      checks++;
      if (kbd.ready !== 1'b0) begin
        errors++;
        $display("FAIL push_pop_dup: offset %0d ready=%b want 0", k, kbd.ready);
      end
    end
  endtask

  task automatic test_partial_reset();
    send_bit(1'b0);
    for (int unsigned i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    clrn = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    checks++;
    if (kbd.overflow !== exp_ovf || kbd.ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: overflow=%b ready=%b want 0 0", kbd.overflow, kbd.ready);
    end
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    drain_one("midreset_5a");
    @(negedge clk);
    checks++;
    if (kbd.ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_extra: ready=%b want 0", kbd.ready);
    end
  endtask

  initial begin
    clrn           = 1'b1;
    ps2_clk        = 1'b1;
    ps2_data       = 1'b1;
    kbd.nextdata_n = 1'b1;
    repeat (3) @(negedge clk);
    clrn = 1'b0;
    test_reset();
    test_single();
    test_break();
    test_parity();
    test_overflow();
    test_back_to_back();
    test_partial_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
